mem_responder: RTL
==================

# mem_responder

Single-port word memory that answers the CPU's instruction-fetch and LW/SW requests through a valid/ready request channel and a valid/ready response channel. It sits between the multi-cycle control unit/datapath (the initiator) and the on-chip storage array. It inserts a parameterised number of wait cycles per access, which lets the control FSM be exercised against realistic memory latency.

## Interface
- ADDR_WIDTH, 8, word-address width
- DATA_WIDTH, 16, word width; matches the 16-bit instruction/data word
- DEPTH, 256, implemented words; must be ≤ 2**ADDR_WIDTH
- LATENCY, 2, wait cycles per access; legal range ≥ 1
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder accepts a request this cycle
- req_write  in  1  1 = store (SW), 0 = load/fetch
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  store data
- resp_valid  out  1  response available
- resp_ready  in  1  initiator consumes the response
- resp_rdata  out  DATA_WIDTH  read data; for a store, the written data
- resp_err  out  1  the address was ≥ DEPTH
- busy  out  1  a transaction is in flight (state ≠ IDLE)

## Operation
- FSM states: MEM_IDLE, MEM_WAIT, MEM_RESP.
- **MEM_IDLE:** req_ready=1. On req_valid && req_ready, capture addr, wdata and write, load cnt=LATENCY-1, and go to MEM_WAIT.
- **MEM_WAIT:** req_ready=0. If cnt≠0, decrement cnt. If cnt==0, perform the access and go to MEM_RESP.
  - Read: the resp_rdata register is loaded with mem[addr].
  - Write: mem[addr] takes wdata, and resp_rdata takes wdata.
  - Out-of-range address (addr ≥ DEPTH): a read returns 0, a write is dropped, and resp_err is set to 1. Otherwise resp_err=0.
- **MEM_RESP:** resp_valid=1. resp_rdata and resp_err are held stable until the handshake. On resp_valid && resp_ready, go to MEM_IDLE. No new request is accepted in this state, so there is at most one outstanding transaction.
- Request fields are sampled only at the accept edge. Later changes on req_* have no effect.
- Width rules:
  - cnt width is $clog2(LATENCY+1).
  - The address compare is unsigned, at ADDR_WIDTH bits.
  - No partial-word writes.
- Reset (asserted at any time, including mid-transaction):
  - State goes to MEM_IDLE immediately.
  - The in-flight transaction is abandoned. A pending write that has not reached its access edge is not performed.
  - Memory contents are not cleared and are undefined after power-up.
- Reset values of outputs:
  - req_ready is 0 while resetn=0 and 1 in the first cycle after release.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0.

## Timing
- Request accepted at edge N.
- Access performed at edge N+LATENCY.
- resp_valid is high from the cycle after edge N+LATENCY.
- With resp_ready held high, the response handshake occurs at edge N+LATENCY+1, and req_ready is high again in the following cycle.
- Minimum issue interval: LATENCY+2 cycles.
- resp_valid is never deasserted without a handshake.
- All outputs are registered or decoded from state only; there is no combinational path from req_* or resp_ready to any output.

## Structure
- Add the following to defs_pkg:
  - mem_state_t enum {MEM_IDLE, MEM_WAIT, MEM_RESP}
  - mem_req_t packed struct {write, addr, wdata}, used as the capture register.
- One sub-module, mem_array: DEPTH×DATA_WIDTH storage with synchronous write, synchronous read and a single port. It is driven only from MEM_WAIT with cnt==0.
- Top level: FSM, wait counter, capture register, range check, response registers.

## Test plan
- **Reset:** hold resetn=0 for 3 cycles with req_valid=1 → req_ready=0, resp_valid=0, busy=0, and no request is accepted. After release, req_ready=1 in the first cycle.
- **Store then load, LATENCY=2:**
  - SW addr 0x10 data 0xBEEF, accepted at edge N → resp_valid rises after edge N+2, with resp_rdata=0xBEEF and resp_err=0.
  - A following LW 0x10 → resp_rdata=0xBEEF.
- **Backpressure:** resp_ready held low for 5 cycles → resp_valid and resp_rdata are stable for all 5 cycles, and req_ready=0 throughout. One cycle after resp_ready rises, state is MEM_IDLE.
- **Out of range, DEPTH=200:**
  - SW addr 0xF0 data 0x1234 → resp_err=1, no array write.
  - LW 0xF0 → resp_rdata=0x0000, resp_err=1.
  - LW 0x00 (written earlier with 0x5555) → 0x5555, resp_err=0.
- **Reset mid-transaction:**
  - Setup: write 0x1111 to addr 3 and complete it normally.
  - Then accept SW addr 3 data 0xAAAA and assert resetn=0 one cycle later, before the access edge → busy=0 and resp_valid=0 immediately. After release, LW 3 returns 0x1111.
- **LATENCY=1 back-to-back:** 4 consecutive LW requests with resp_ready tied high → each response arrives 1 cycle after accept, and a new request is accepted every 3 cycles.

Source files
------------

// File: rtl/defs_pkg.sv
// Shared types for the memory responder: FSM state encoding and the request capture record.
package defs_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 16;

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_WAIT,
      MEM_RESP
   } mem_state_t;

   typedef struct packed {
      logic                  write;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with synchronous write and registered (write-through) read.
module mem_array #(
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // A store echoes its own data so the response always carries the accessed word.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory responder: one outstanding access, fixed wait cycles, range-checked addresses.
module mem_responder
   import defs_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_ADDR_W,
   parameter int DATA_WIDTH = MEM_DATA_W,
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  busy
);

   localparam int CW = $clog2(LATENCY + 1);

   mem_state_t            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  err_q, err_d;
   mem_req_t              cap_q;
   logic                  accept;
   logic                  access;
   logic                  in_range;
   logic                  arr_en;
   logic [DATA_WIDTH-1:0] arr_rdata;

   assign accept   = (state_q == MEM_IDLE) && req_valid;
   assign access   = (state_q == MEM_WAIT) && (cnt_q == '0);
   assign in_range = 32'(cap_q.addr) < 32'(DEPTH);
   assign arr_en   = access && in_range;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         MEM_IDLE: begin
            if (req_valid) begin
               state_d = MEM_WAIT;
               cnt_d   = CW'(LATENCY - 1);
            end
         end
         MEM_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = MEM_RESP;
               err_d   = !in_range;
            end
         end
         MEM_RESP: begin
            if (resp_ready) state_d = MEM_IDLE;
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Request fields are frozen at the accept edge; later req_* activity is ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         cap_q <= '{write: req_write, addr: req_addr, wdata: req_wdata};
      end
   end

   mem_array #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk     (clk),
      .en_i    (arr_en),
      .we_i    (cap_q.write),
      .addr_i  (cap_q.addr),
      .wdata_i (cap_q.wdata),
      .rdata_o (arr_rdata)
   );

   // The array output register doubles as the response data register; out-of-range reads as zero.
   assign req_ready  = resetn && (state_q == MEM_IDLE);
   assign resp_valid = (state_q == MEM_RESP);
   assign busy       = (state_q != MEM_IDLE);
   assign resp_err   = err_q;
   assign resp_rdata = (resp_valid && !err_q) ? arr_rdata : '0;

endmodule
